// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: coin acceptance, price check, dispense handshake,
// change return and inactivity refund driven by a tick prescaler plus seconds counter.
module vend_sequencer #(
    parameter int unsigned TICKS_PER_SEC = 256,
    parameter int unsigned TIMEOUT_SEC   = 5,
    parameter int unsigned CREDIT_MAX    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       sel_valid,
    input  logic [7:0] sel_price,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       timeout,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Dispenser handshake: disp_req rises with entry to DISPENSE and stays high until
    // disp_ack is sampled high; disp_ack is a level the dispenser holds until disp_req drops.

    localparam int unsigned    TW        = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     SEC_LAST  = 4'(TIMEOUT_SEC - 1);
    localparam logic [8:0]     CMAX      = 9'(CREDIT_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        CHECK    = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } state_t;

    state_t        r_state;
    logic [7:0]    r_credit;
    logic [7:0]    r_price;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_sec;
    logic          r_disp_req;
    logic          r_change_valid;
    logic [7:0]    r_change_amt;
    logic          r_coin_reject;
    logic          r_timeout;
    logic          r_busy;

    logic [7:0]    w_coin_units;
    logic [8:0]    w_coin_sum;
    logic          w_coin_ok;
    logic          w_expire;

    always_comb begin
        w_coin_units = 8'd0;
        case (coin_val)
            2'b01:   w_coin_units = 8'd1;
            2'b10:   w_coin_units = 8'd2;
            2'b11:   w_coin_units = 8'd5;
            default: w_coin_units = 8'd0;
        endcase
    end

    assign w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin_units};
    assign w_coin_ok  = coin_valid && (r_state == IDLE || r_state == COLLECT) &&
                        (coin_val != 2'b00) && (w_coin_sum <= CMAX);
    // Fires on the edge at which the seconds counter would reach TIMEOUT_SEC.
    assign w_expire   = (r_tick == TICK_LAST) && (r_sec == SEC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_credit       <= 8'd0;
            r_price        <= 8'd0;
            r_tick         <= '0;
            r_sec          <= 4'd0;
            r_disp_req     <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_amt   <= 8'd0;
            r_coin_reject  <= 1'b0;
            r_timeout      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_coin_reject  <= coin_valid && !w_coin_ok;
            r_timeout      <= 1'b0;
            r_change_valid <= 1'b0;
            if (w_coin_ok)
                r_credit <= w_coin_sum[7:0];

            case (r_state)
                IDLE: begin
                    if (w_coin_ok) begin
                        r_state <= COLLECT;
                        r_busy  <= 1'b1;
                        r_tick  <= '0;
                        r_sec   <= 4'd0;
                    end
                end
                COLLECT: begin
                    // A coin landing with cancel/select is already in r_credit by the next state.
                    if (cancel) begin
                        r_state <= CHANGE;
                    end else if (sel_valid) begin
                        r_price <= sel_price;
                        r_state <= CHECK;
                    end else if (w_coin_ok) begin
                        r_tick <= '0;
                        r_sec  <= 4'd0;
                    end else if (w_expire) begin
                        r_state   <= CHANGE;
                        r_timeout <= 1'b1;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        r_sec  <= r_sec + 4'd1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                CHECK: begin
                    if (r_credit >= r_price) begin
                        r_credit   <= r_credit - r_price;
                        r_state    <= DISPENSE;
                        r_disp_req <= 1'b1;
                    end else begin
                        r_state <= COLLECT;
                        r_tick  <= '0;
                        r_sec   <= 4'd0;
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        r_disp_req <= 1'b0;
                        r_state    <= CHANGE;
                    end
                end
                CHANGE: begin
                    if (r_credit != 8'd0) begin
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                    end
                    r_credit <= 8'd0;
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign disp_req     = r_disp_req;
    assign change_valid = r_change_valid;
    assign change_amt   = r_change_amt;
    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign timeout      = r_timeout;
    assign busy         = r_busy;
    assign dbg_state    = r_state;

endmodule
